// File: rtl/iob_fifo2axis.sv
// rtl/iob_fifo2axis.sv - FIFO read-port drain presenting an AXI-Stream master with tlast framing
//
// Pops words from a synchronous FIFO (1-cycle read latency) into a 2-entry
// output buffer and streams them out, one word per cycle while tready=1.
//
// Ports:
//   clk_i, cen_i, arst_n_i, rst_i  clock, clock enable, async reset (low), sync clear (high)
//   en_i                           1 = keep issuing FIFO reads, 0 = drain what is held
//   len_i                          beats per frame (0 = never assert tlast)
//   fifo_r_en_o / fifo_r_data_i / fifo_empty_i   FIFO read port
//   axis_tvalid_o / axis_tready_i / axis_tdata_o / axis_tlast_o   stream master
//   count_o                        beats accepted in the current frame
module iob_fifo2axis #(
    parameter int DATA_W = 21,
    parameter int LEN_W  = 16
) (
    input  logic              clk_i,
    input  logic              cen_i,
    input  logic              arst_n_i,
    input  logic              rst_i,
    input  logic              en_i,
    input  logic [LEN_W-1:0]  len_i,
    output logic              fifo_r_en_o,
    input  logic [DATA_W-1:0] fifo_r_data_i,
    input  logic              fifo_empty_i,
    output logic              axis_tvalid_o,
    input  logic              axis_tready_i,
    output logic [DATA_W-1:0] axis_tdata_o,
    output logic              axis_tlast_o,
    output logic [LEN_W-1:0]  count_o
);

    logic [DATA_W-1:0] mem0;
    logic [DATA_W-1:0] mem1;
    logic              head;
    logic              tail;
    logic [1:0]        occ;
    logic              inflight;
    logic [LEN_W-1:0]  count;

    logic              pop;
    logic [2:0]        committed;

    assign pop = axis_tvalid_o & axis_tready_i;

    // Slots that will be occupied after this edge: held words plus the word
    // returning from last cycle's read, minus the one leaving now. A new read
    // is only issued when a slot is guaranteed for it one cycle later.
    assign committed = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};

    assign fifo_r_en_o = cen_i & arst_n_i & en_i & ~fifo_empty_i & ~rst_i
                       & (committed < 3'd2);

    assign axis_tvalid_o = (occ != 2'd0);
    assign axis_tdata_o  = axis_tvalid_o ? (head ? mem1 : mem0) : '0;
    assign axis_tlast_o  = axis_tvalid_o & (len_i != '0)
                         & (count == len_i - LEN_W'(1));
    assign count_o       = count;

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            mem0     <= '0;
            mem1     <= '0;
            head     <= 1'b0;
            tail     <= 1'b0;
            occ      <= 2'd0;
            inflight <= 1'b0;
            count    <= '0;
        end else if (cen_i) begin
            if (rst_i) begin
                // Clearing inflight drops any word still returning from the FIFO.
                mem0     <= '0;
                mem1     <= '0;
                head     <= 1'b0;
                tail     <= 1'b0;
                occ      <= 2'd0;
                inflight <= 1'b0;
                count    <= '0;
            end else begin
                inflight <= fifo_r_en_o;
                if (inflight) begin
                    if (tail) begin
                        mem1 <= fifo_r_data_i;
                    end else begin
                        mem0 <= fifo_r_data_i;
                    end
                    tail <= ~tail;
                end
                if (pop) begin
                    head  <= ~head;
                    count <= axis_tlast_o ? '0 : count + LEN_W'(1);
                end
                occ <= committed[1:0];
            end
        end
    end

endmodule

// File: tb/tb_iob_fifo2axis.sv
// tb/tb_iob_fifo2axis.sv - self-checking bench for iob_fifo2axis
module tb_iob_fifo2axis;

    localparam int DW = 21;
    localparam int LW = 16;

    logic          clk_i = 1'b0;
    logic          cen_i;
    logic          arst_n_i;
    logic          rst_i;
    logic          en_i;
    logic [LW-1:0] len_i;
    logic          fifo_r_en_o;
    logic [DW-1:0] fifo_r_data_i;
    logic          fifo_empty_i;
    logic          axis_tvalid_o;
    logic          axis_tready_i;
    logic [DW-1:0] axis_tdata_o;
    logic          axis_tlast_o;
    logic [LW-1:0] count_o;

    always #5 clk_i = ~clk_i;

    iob_fifo2axis #(.DATA_W(DW), .LEN_W(LW)) dut (
        .clk_i         (clk_i),
        .cen_i         (cen_i),
        .arst_n_i      (arst_n_i),
        .rst_i         (rst_i),
        .en_i          (en_i),
        .len_i         (len_i),
        .fifo_r_en_o   (fifo_r_en_o),
        .fifo_r_data_i (fifo_r_data_i),
        .fifo_empty_i  (fifo_empty_i),
        .axis_tvalid_o (axis_tvalid_o),
        .axis_tready_i (axis_tready_i),
        .axis_tdata_o  (axis_tdata_o),
        .axis_tlast_o  (axis_tlast_o),
        .count_o       (count_o)
    );

    // Flags: [4]=en [3]=tready [2]=fifo_r_en [1]=tvalid [0]=tlast
    typedef struct {
        logic [4:0]    f;
        logic [DW-1:0] d;
        logic [LW-1:0] c;
    } vec_t;

    vec_t tv[12];

    int checks   = 0;
    int failures = 0;

    logic [DW-1:0] q[$];      // upstream FIFO contents
    logic [DW-1:0] exp_q[$];  // words read from the FIFO and not yet delivered
    logic [LW-1:0] mbeat;     // beat position within the current frame
    int            rx;
    int            rd_cnt;
    int            tl_cnt;
    logic          s_ren;
    logic          s_hs;
    logic          s_rst;
    logic          s_cen;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    // Negedge: compare outputs with the model and sample what the next edge will see.
    task automatic at_neg();
        @(negedge clk_i);
        if (!arst_n_i) begin
            chk("rst_tvalid", 32'(axis_tvalid_o), 32'd0);
            chk("rst_count", 32'(count_o), 32'd0);
            chk("rst_ren", 32'(fifo_r_en_o), 32'd0);
        end else begin
            chk("count", 32'(count_o), 32'(mbeat));
            if (axis_tvalid_o) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL tvalid_extra actual=tvalid 1 required=no pending word");
                end else if (axis_tdata_o !== exp_q[0]) begin
                    failures++;
                    $display("FAIL tdata actual=0x%0h required=0x%0h", axis_tdata_o, exp_q[0]);
                end
                chk("tlast", 32'(axis_tlast_o), 32'((len_i != '0) && (mbeat == len_i - 16'd1)));
            end else begin
                chk("idle_tdata", 32'(axis_tdata_o), 32'd0);
                chk("idle_tlast", 32'(axis_tlast_o), 32'd0);
            end
            chk("read_while_empty", 32'(fifo_r_en_o & fifo_empty_i), 32'd0);
        end
        s_ren = fifo_r_en_o;
        s_hs  = axis_tvalid_o & axis_tready_i & cen_i & ~rst_i & arst_n_i;
        s_rst = (rst_i & cen_i) | ~arst_n_i;
        s_cen = cen_i;
        if (s_hs && axis_tlast_o) tl_cnt++;
    endtask

    // Just after posedge: advance the FIFO model and the scoreboard.
    task automatic at_pos();
        logic [DW-1:0] w;
        @(posedge clk_i);
        #1;
        if (s_cen) begin
            if (s_ren) begin
                checks++;
                if (q.size() == 0) begin
                    failures++;
                    $display("FAIL read_on_empty_fifo actual=read required=no read");
                end else begin
                    w = q.pop_front();
                    fifo_r_data_i = w;
                    exp_q.push_back(w);
                    rd_cnt++;
                end
            end else begin
                fifo_r_data_i = DW'($urandom);
            end
            fifo_empty_i = (q.size() == 0);
        end
        if (s_rst) begin
            exp_q.delete();
            mbeat = '0;
        end else if (s_hs) begin
            if (exp_q.size() != 0) w = exp_q.pop_front();
            rx++;
            mbeat = ((len_i != '0) && (mbeat == len_i - 16'd1)) ? '0 : mbeat + 16'd1;
        end
    endtask

    task automatic cycle();
        at_neg();
        at_pos();
    endtask

    task automatic clear_all();
        en_i = 1'b0;
        axis_tready_i = 1'b1;
        rst_i = 1'b1;
        q.delete();
        cycle();
        rst_i = 1'b0;
        repeat (2) cycle();
    endtask

    task automatic preload(input int base);
        for (int i = 0; i < 8; i++) q.push_back(DW'(base + i));
    endtask

    initial begin
        int sent;
        int first_tl;

        tv[0]  = '{5'b11000, 21'd0, 16'd0};
        tv[1]  = '{5'b11100, 21'd0, 16'd0};
        tv[2]  = '{5'b11100, 21'd0, 16'd0};
        tv[3]  = '{5'b11110, 21'd1, 16'd0};
        tv[4]  = '{5'b11110, 21'd2, 16'd1};
        tv[5]  = '{5'b11110, 21'd3, 16'd2};
        tv[6]  = '{5'b11111, 21'd4, 16'd3};
        tv[7]  = '{5'b11110, 21'd5, 16'd0};
        tv[8]  = '{5'b11110, 21'd6, 16'd1};
        tv[9]  = '{5'b11010, 21'd7, 16'd2};
        tv[10] = '{5'b11011, 21'd8, 16'd3};
        tv[11] = '{5'b11000, 21'd0, 16'd0};

        cen_i = 1'b1; arst_n_i = 1'b0; rst_i = 1'b0; en_i = 1'b0;
        len_i = 16'd4; axis_tready_i = 1'b0;
        fifo_r_data_i = '0; fifo_empty_i = 1'b1;
        mbeat = '0; rx = 0; rd_cnt = 0; tl_cnt = 0;
        s_ren = 1'b0; s_hs = 1'b0; s_rst = 1'b1; s_cen = 1'b1;
        repeat (2) cycle();
        arst_n_i = 1'b1;
        cycle();

        // 1: preloaded 1..8, tready=1, len=4, cycle-exact table
        for (int k = 0; k < 12; k++) begin
            if (k == 0) preload(1);
            en_i = tv[k].f[4];
            axis_tready_i = tv[k].f[3];
            at_neg();
            chk($sformatf("t1_ren[%0d]", k), 32'(fifo_r_en_o), 32'(tv[k].f[2]));
            chk($sformatf("t1_tvalid[%0d]", k), 32'(axis_tvalid_o), 32'(tv[k].f[1]));
            chk($sformatf("t1_tdata[%0d]", k), 32'(axis_tdata_o), 32'(tv[k].d));
            chk($sformatf("t1_tlast[%0d]", k), 32'(axis_tlast_o), 32'(tv[k].f[0]));
            chk($sformatf("t1_count[%0d]", k), 32'(count_o), 32'(tv[k].c));
            at_pos();
        end

        // 2: stall 10 cycles, then release
        clear_all();
        preload(1);
        en_i = 1'b1; axis_tready_i = 1'b0; rd_cnt = 0;
        for (int k = 0; k < 10; k++) begin
            at_neg();
            if (k >= 3) begin
                chk("t2_stall_tvalid", 32'(axis_tvalid_o), 32'd1);
                chk("t2_stall_tdata", 32'(axis_tdata_o), 32'd1);
            end
            at_pos();
        end
        chk("t2_reads_during_stall", 32'(rd_cnt), 32'd2);
        axis_tready_i = 1'b1;
        for (int j = 0; j < 8; j++) begin
            at_neg();
            chk($sformatf("t2_tvalid[%0d]", j), 32'(axis_tvalid_o), 32'd1);
            chk($sformatf("t2_tdata[%0d]", j), 32'(axis_tdata_o), 32'(j + 1));
            at_pos();
        end
        at_neg();
        chk("t2_drained", 32'(axis_tvalid_o), 32'd0);
        at_pos();

        // 3: random tready and random FIFO fill, len=7
        clear_all();
        len_i = 16'd7; en_i = 1'b1; rx = 0; tl_cnt = 0; sent = 0;
        for (int cyc = 0; cyc < 20000 && rx < 1000; cyc++) begin
            axis_tready_i = 1'($urandom_range(0, 1));
            if (sent < 1000 && $urandom_range(0, 9) < 7) begin
                q.push_back(DW'($urandom));
                sent++;
            end
            cycle();
        end
        chk("t3_beats", 32'(rx), 32'd1000);
        chk("t3_tlasts", 32'(tl_cnt), 32'd142);

        // 4: en dropped after three reads
        clear_all();
        len_i = 16'd4;
        preload(1);
        en_i = 1'b1; axis_tready_i = 1'b1; rd_cnt = 0; rx = 0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            cycle();
            if (rd_cnt >= 3) en_i = 1'b0;
        end
        chk("t4_reads", 32'(rd_cnt), 32'd3);
        chk("t4_beats", 32'(rx), 32'd3);
        at_neg();
        chk("t4_tvalid_end", 32'(axis_tvalid_o), 32'd0);
        chk("t4_ren_end", 32'(fifo_r_en_o), 32'd0);
        at_pos();

        // 5: async reset mid-frame with two words held
        clear_all();
        preload(1);
        en_i = 1'b1; axis_tready_i = 1'b1; rx = 0;
        for (int cyc = 0; cyc < 20 && rx < 1; cyc++) cycle();
        axis_tready_i = 1'b0;
        repeat (4) cycle();
        at_neg();
        chk("t5_mid_tvalid", 32'(axis_tvalid_o), 32'd1);
        chk("t5_mid_count", 32'(count_o), 32'd1);
        at_pos();
        #2;
        arst_n_i = 1'b0;
        #1;
        chk("t5_async_tvalid", 32'(axis_tvalid_o), 32'd0);
        chk("t5_async_count", 32'(count_o), 32'd0);
        chk("t5_async_tdata", 32'(axis_tdata_o), 32'd0);
        en_i = 1'b0; q.delete(); exp_q.delete(); mbeat = '0;
        cycle();
        arst_n_i = 1'b1;
        repeat (2) cycle();
        preload(32'h100);
        en_i = 1'b1; axis_tready_i = 1'b1; rx = 0; first_tl = -1;
        for (int cyc = 0; cyc < 30 && rx < 8; cyc++) begin
            at_neg();
            if (axis_tvalid_o && axis_tlast_o && first_tl < 0) first_tl = rx + 1;
            at_pos();
        end
        chk("t5_beats", 32'(rx), 32'd8);
        chk("t5_first_tlast_beat", 32'(first_tl), 32'd4);

        // 6: clock enable low for five cycles mid-stream
        clear_all();
        preload(32'h200);
        en_i = 1'b1; axis_tready_i = 1'b1; rx = 0;
        for (int cyc = 0; cyc < 20 && rx < 2; cyc++) cycle();
        cen_i = 1'b0;
        for (int k = 0; k < 5; k++) begin
            at_neg();
            chk("t6_ren_frozen", 32'(fifo_r_en_o), 32'd0);
            chk("t6_tvalid_frozen", 32'(axis_tvalid_o), 32'd1);
            chk("t6_count_frozen", 32'(count_o), 32'd2);
            at_pos();
        end
        cen_i = 1'b1;
        for (int cyc = 0; cyc < 30 && rx < 8; cyc++) cycle();
        chk("t6_beats", 32'(rx), 32'd8);
        at_neg();
        chk("t6_drained", 32'(axis_tvalid_o), 32'd0);
        at_pos();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
